// File: rtl/dcm_prog_pkg.sv
// rtl/dcm_prog_pkg.sv - shared types, frame headers and helpers for the DCM programming controller
package dcm_prog_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_D,
        ST_GAP_D,
        ST_SEND_M,
        ST_GAP_M,
        ST_SEND_GO,
        ST_WAIT,
        ST_FIN
    } state_t;

    // Command headers, bit 0 goes on the wire first
    localparam logic [1:0] HDR_D = 2'b01;
    localparam logic [1:0] HDR_M = 2'b11;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/dcm_prog_shifter.sv
// rtl/dcm_prog_shifter.sv - loadable LSB-first frame shifter shared by the D and M commands
module dcm_prog_shifter
    import dcm_prog_pkg::*;
#(
    parameter int MDW = 8
) (
    input  logic           PROGCLK,
    input  logic           RST,
    input  logic           load,
    input  logic           shift,
    input  logic [MDW+1:0] load_data,
    output logic           sdata,
    output logic           last
);
    localparam int BW = clog2(MDW + 2);
    localparam logic [BW-1:0] LAST_IDX = BW'(MDW + 1);

    logic [MDW+1:0] sr_q, sr_d;
    logic [BW-1:0]  cnt_q, cnt_d;

    // Load a new frame or advance one bit; the counter marks the final bit
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = load_data;
            cnt_d = '0;
        end else if (shift) begin
            sr_d  = sr_q >> 1;
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Shift register and bit counter
    always_ff @(posedge PROGCLK) begin
        if (RST) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign sdata = sr_q[0];
    assign last  = (cnt_q == LAST_IDX);

endmodule

// File: rtl/dcm_prog_ctrl.sv
// rtl/dcm_prog_ctrl.sv - multi-channel DCM_CLKGEN M/D programming controller with lock timeout
module dcm_prog_ctrl
    import dcm_prog_pkg::*;
#(
    parameter int NCH     = 1,
    parameter int MDW     = 8,
    parameter int GAP     = 4,
    parameter int LOCK_TO = 65535,
    parameter int CHW     = (clog2(NCH) > 1) ? clog2(NCH) : 1
) (
    input  logic           PROGCLK,
    input  logic           RST,
    input  logic           GO,
    input  logic [CHW-1:0] CH,
    input  logic [MDW-1:0] M,
    input  logic [MDW-1:0] D,
    output logic           BUSY,
    output logic           DONE,
    output logic           ERR,
    output logic [NCH-1:0] PROGEN,
    output logic [NCH-1:0] PROGDATA,
    input  logic [NCH-1:0] PROGDONE,
    input  logic [NCH-1:0] LOCKED
);
    localparam int GW = clog2(GAP + 1);
    localparam int TW = clog2(LOCK_TO + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(LOCK_TO);

    state_t         state_q, state_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [MDW-1:0] m_q, m_d;
    logic           armed_q, armed_d;
    logic           fail_q, fail_d;
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [TW-1:0]  to_q, to_d;
    logic [NCH-1:0] progen_q, progen_d;
    logic [NCH-1:0] progdata_q, progdata_d;
    logic [NCH-1:0] pd_s1_q, pd_s2_q, lk_s1_q, lk_s2_q;

    logic           sh_load, sh_shift, sh_bit, sh_last;
    logic [MDW+1:0] sh_load_data;
    logic           pd_sel, lk_sel, ch_valid, in_req, gap_end, tx_en, tx_bit;

    dcm_prog_shifter #(.MDW(MDW)) u_shifter (
        .PROGCLK   (PROGCLK),
        .RST       (RST),
        .load      (sh_load),
        .shift     (sh_shift),
        .load_data (sh_load_data),
        .sdata     (sh_bit),
        .last      (sh_last)
    );

    // Pick the synchronised status of the channel being programmed
    always_comb begin
        pd_sel = 1'b0;
        lk_sel = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_q == CHW'(i)) begin
                pd_sel = pd_s2_q[i];
                lk_sel = lk_s2_q[i];
            end
        end
    end

    assign ch_valid = ({1'b0, CH} < (CHW + 1)'(NCH));
    assign in_req   = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign gap_end  = (gap_q == GAP_LAST);

    // Sequencer: next state, frame loading, wait/timeout decisions and output staging
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        m_d          = m_q;
        armed_d      = armed_q;
        fail_d       = fail_q;
        err_d        = err_q;
        done_d       = 1'b0;
        busy_d       = in_req;
        gap_d        = '0;
        to_d         = '0;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        sh_load_data = {D, HDR_D};
        tx_en        = 1'b0;
        tx_bit       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                armed_d = 1'b0;
                if (GO) begin
                    ch_d  = CH;
                    m_d   = M;
                    err_d = 1'b0;
                    if (ch_valid) begin
                        sh_load = 1'b1;
                        fail_d  = 1'b0;
                        state_d = ST_SEND_D;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_SEND_D: begin
                tx_en    = 1'b1;
                tx_bit   = sh_bit;
                sh_shift = 1'b1;
                if (sh_last) state_d = ST_GAP_D;
            end
            ST_GAP_D: begin
                gap_d = gap_end ? '0 : gap_q + 1'b1;
                if (gap_end) begin
                    sh_load      = 1'b1;
                    sh_load_data = {m_q, HDR_M};
                    state_d      = ST_SEND_M;
                end
            end
            ST_SEND_M: begin
                tx_en    = 1'b1;
                tx_bit   = sh_bit;
                sh_shift = 1'b1;
                if (sh_last) state_d = ST_GAP_M;
            end
            ST_GAP_M: begin
                gap_d = gap_end ? '0 : gap_q + 1'b1;
                if (gap_end) state_d = ST_SEND_GO;
            end
            ST_SEND_GO: begin
                tx_en   = 1'b1;
                to_d    = TW'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                to_d = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
                if (armed_q && pd_sel && lk_sel) begin
                    fail_d  = 1'b0;
                    state_d = ST_FIN;
                end else if (to_q == TO_MAX) begin
                    fail_d  = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                err_d   = fail_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The DCM drops PROGDONE once it starts taking commands; only then is a high PROGDONE meaningful
        if (in_req && !pd_sel) armed_d = 1'b1;

        for (int i = 0; i < NCH; i++) begin
            progen_d[i]   = tx_en && (ch_q == CHW'(i));
            progdata_d[i] = tx_en && tx_bit && (ch_q == CHW'(i));
        end
    end

    // State, control registers and registered outputs
    always_ff @(posedge PROGCLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            m_q        <= '0;
            armed_q    <= 1'b0;
            fail_q     <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            gap_q      <= '0;
            to_q       <= '0;
            progen_q   <= '0;
            progdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            m_q        <= m_d;
            armed_q    <= armed_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            gap_q      <= gap_d;
            to_q       <= to_d;
            progen_q   <= progen_d;
            progdata_q <= progdata_d;
        end
    end

    // Two-flop synchronisers for the DCM status inputs
    always_ff @(posedge PROGCLK) begin
        if (RST) begin
            pd_s1_q <= '0;
            pd_s2_q <= '0;
            lk_s1_q <= '0;
            lk_s2_q <= '0;
        end else begin
            pd_s1_q <= PROGDONE;
            pd_s2_q <= pd_s1_q;
            lk_s1_q <= LOCKED;
            lk_s2_q <= lk_s1_q;
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign PROGEN   = progen_q;
    assign PROGDATA = progdata_q;

endmodule
